btn_conditioner: RTL and testbench

- Conditions the four push-button inputs from the MKR header pins for the VGA game logic, which runs on the 120 MHz PLL clock.
- Per channel: 2-flop synchronizer, debounce filter, and registered level output.
- Also produces one-cycle press, release and auto-repeat pulses.
- Sits directly upstream of the game block; the game consumes only clean, synchronous signals from here.

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_conditioner_if.sv | 6 +
 rtl/btn_debounce_ch.sv | 75 +++++++
 rtl/btn_conditioner.sv | 39 +++
 tb/tb_btn_conditioner.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: repeat-FSM states, 120 MHz timing defaults and counter sizing
// shared by the button conditioner blocks.
package btn_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, RPT} rptState_t;
    localparam int DEBOUNCE_120M     = 1200000;
    localparam int REPEAT_DELAY_120M = 48000000;
    localparam int REPEAT_RATE_120M  = 12000000;
    function automatic int cntWidth(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button pins in, conditioned level and pulse vectors out.
interface btn_conditioner_if #(parameter int N_BTN = 4);
    logic [N_BTN-1:0] iBTN, oLEVEL, oPRESS, oRELEASE, oREPEAT;
    modport master(output iBTN, input oLEVEL, oPRESS, oRELEASE, oREPEAT);
    modport slave(input iBTN, output oLEVEL, oPRESS, oRELEASE, oREPEAT);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- synchronizer, debounce filter,
// registered level, press/release pulses and auto-repeat FSM.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_120M,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_120M,
    parameter int REPEAT_RATE     = REPEAT_RATE_120M
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iBTN,
    output logic oLEVEL,
    output logic oPRESS,
    output logic oRELEASE,
    output logic oREPEAT
);
    localparam int DW = cntWidth(DEBOUNCE_CYCLES);
    localparam int RW = cntWidth(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic s1, s2, deb, rise, fall, rptDone;
    logic [DW-1:0] debCnt;
    logic [RW-1:0] rptCnt;
    rptState_t state;

    // deb is the filtered state; oLEVEL and the pulses are registered one stage behind it
    assign rise    = deb & ~oLEVEL;
    assign fall    = ~deb & oLEVEL;
    assign rptDone = (state == DELAY && rptCnt == DLY_LAST) || (state == RPT && rptCnt == RATE_LAST);

    // synchronizer resets to the normalized released level so reset exit never looks like a press
    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            deb      <= 1'b0;
            debCnt   <= '0;
            oLEVEL   <= 1'b0;
            oPRESS   <= 1'b0;
            oRELEASE <= 1'b0;
        end else begin
            s1       <= iBTN ^ ACTIVE_LOW;
            s2       <= s1;
            debCnt   <= (s2 == deb || debCnt == DEB_LAST) ? '0 : debCnt + 1'b1;
            deb      <= (s2 != deb && debCnt == DEB_LAST) ? s2 : deb;
            oLEVEL   <= deb;
            oPRESS   <= rise;
            oRELEASE <= fall;
        end

    // release has priority over a coinciding repeat terminal count
    always_ff @(posedge iCLK or posedge iRESET)
        if (iRESET) begin
            state   <= IDLE;
            rptCnt  <= '0;
            oREPEAT <= 1'b0;
        end else begin
            oREPEAT <= rptDone & ~fall;
            if (fall) begin
                state  <= IDLE;
                rptCnt <= '0;
            end else if (rise) begin
                state  <= DELAY;
                rptCnt <= '0;
            end else if (rptDone) begin
                state  <= RPT;
                rptCnt <= '0;
            end else if (state != IDLE)
                rptCnt <= rptCnt + 1'b1;
        end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent button channels feeding the game logic
// with clean, synchronous levels and one-cycle press/release/repeat pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_120M,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_120M,
    parameter int REPEAT_RATE     = REPEAT_RATE_120M
) (
    input logic iCLK,
    input logic iRESET,
    btn_conditioner_if.slave bus
);
    logic [N_BTN-1:0] level, press, release_, repeat_;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .ACTIVE_LOW(ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE(REPEAT_RATE)
        ) u_ch (
            .iCLK(iCLK),
            .iRESET(iRESET),
            .iBTN(bus.iBTN[i]),
            .oLEVEL(level[i]),
            .oPRESS(press[i]),
            .oRELEASE(release_[i]),
            .oREPEAT(repeat_[i])
        );
    end

    assign bus.oLEVEL   = level;
    assign bus.oPRESS   = press;
    assign bus.oRELEASE = release_;
    assign bus.oREPEAT  = repeat_;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of reset, debounce latency, glitch rejection,
// repeat timing, release/repeat collision and reset during a held press.
module tb_btn_conditioner;
    localparam int N = 4, DEB = 8, RD = 20, RR = 5;

    logic wCLK = 1'b0;
    logic wRESET = 1'b1;
    int nChecks = 0, nPass = 0;
    logic [15:0] acc;

    btn_conditioner_if #(.N_BTN(N)) bus();

    btn_conditioner #(
        .N_BTN(N),
        .ACTIVE_LOW(1'b1),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .iCLK(wCLK),
        .iRESET(wRESET),
        .bus(bus)
    );

    always #5 wCLK = ~wCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wCLK);
        #1;
    endtask

    function automatic logic [15:0] outsAll();
        return {bus.oLEVEL, bus.oPRESS, bus.oRELEASE, bus.oREPEAT};
    endfunction

    initial begin
        // 1: reset with all pins released, then 100 idle cycles
        bus.iBTN = 4'hF;
        acc = '0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            acc |= outsAll();
        end
        checkVal("t1 outs in reset", acc, 0);
        wRESET = 1'b0;
        acc = '0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            acc |= outsAll();
        end
        checkVal("t1 idle outs", acc, 0);

        // 2: clean press on ch0, sampled first at edge 0, accepted at edge 10
        bus.iBTN[0] = 1'b0;
        tick(10);
        checkVal("t2 level edge9", bus.oLEVEL[0], 0);
        tick(1);
        checkVal("t2 level edge10", bus.oLEVEL[0], 1);
        checkVal("t2 press edge10", bus.oPRESS[0], 1);
        checkVal("t2 others", bus.oLEVEL[3:1], 0);
        tick(1);
        checkVal("t2 press edge11", bus.oPRESS[0], 0);
        checkVal("t2 level edge11", bus.oLEVEL[0], 1);
        bus.iBTN[0] = 1'b1;
        tick(11);
        checkVal("t2 release", bus.oRELEASE[0], 1);
        checkVal("t2 level released", bus.oLEVEL[0], 0);
        tick(1);
        checkVal("t2 release one cycle", bus.oRELEASE[0], 0);

        // 3: 7-cycle glitch rejected, 8-cycle pulse accepted
        bus.iBTN[1] = 1'b0;
        tick(7);
        bus.iBTN[1] = 1'b1;
        acc = '0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            acc[0] |= bus.oLEVEL[1] | bus.oPRESS[1];
        end
        checkVal("t3 glitch7", acc[0], 0);
        bus.iBTN[1] = 1'b0;
        tick(8);
        bus.iBTN[1] = 1'b1;
        tick(2);
        checkVal("t3 pulse8 pre", bus.oLEVEL[1], 0);
        tick(1);
        checkVal("t3 pulse8 press", bus.oPRESS[1], 1);
        checkVal("t3 pulse8 level", bus.oLEVEL[1], 1);
        tick(30);
        checkVal("t3 released", bus.oLEVEL[1], 0);

        // 4: hold ch2, repeats at +20,+25,...; pin released after cycle 60
        bus.iBTN[2] = 1'b0;
        tick(11);
        checkVal("t4 press", bus.oPRESS[2], 1);
        checkVal("t4 no rpt at press", bus.oREPEAT[2], 0);
        for (int c = 1; c <= 90; c++) begin
            tick(1);
            checkVal($sformatf("t4 rpt c%0d", c), bus.oREPEAT[2],
                     32'(c >= RD && c <= 70 && (c - RD) % RR == 0));
            checkVal($sformatf("t4 rel c%0d", c), bus.oRELEASE[2], 32'(c == 71));
            if (c == 60) bus.iBTN[2] = 1'b1;
        end

        // 5: release accepted exactly on the RPT terminal count (cycle 30)
        bus.iBTN[3] = 1'b0;
        tick(11);
        checkVal("t5 press", bus.oPRESS[3], 1);
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            checkVal($sformatf("t5 rpt c%0d", c), bus.oREPEAT[3], 32'(c == 20 || c == 25));
            checkVal($sformatf("t5 rel c%0d", c), bus.oRELEASE[3], 32'(c == 30));
            if (c == 19) bus.iBTN[3] = 1'b1;
        end

        // 6: all pressed together, reset mid-hold, re-accepted after reset
        bus.iBTN = 4'h0;
        tick(11);
        checkVal("t6 press all", bus.oPRESS, 4'hF);
        checkVal("t6 level all", bus.oLEVEL, 4'hF);
        tick(5);
        wRESET = 1'b1;
        #1;
        checkVal("t6 outs at reset", outsAll(), 0);
        acc = '0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            acc |= outsAll();
        end
        checkVal("t6 outs during reset", acc, 0);
        wRESET = 1'b0;
        tick(10);
        checkVal("t6 level pre", bus.oLEVEL, 0);
        checkVal("t6 no release", bus.oRELEASE, 0);
        tick(1);
        checkVal("t6 re-press level", bus.oLEVEL, 4'hF);
        checkVal("t6 re-press pulse", bus.oPRESS, 4'hF);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
